// File: rtl/harness_pkg.sv
// ============================================================================
// Module      : harness_pkg
// Description : Shared types and constants for the harness request/ack blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package harness_pkg;

    localparam int c_ack_lat_max = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    typedef enum logic [1:0] {
        PUSH = 2'd0,
        POP  = 2'd1,
        BAD  = 2'd2
    } req_kind_e;

    // Exactly one of push/pop must be set for a request to be well formed.
    function automatic req_kind_e classify_req(input logic push, input logic pop);
        if (push && !pop) begin
            return PUSH;
        end else if (pop && !push) begin
            return POP;
        end else begin
            return BAD;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/harness_fifo.sv
// ============================================================================
// Module      : harness_fifo
// Description : Single-clock FIFO with occupancy count and head-of-queue data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module harness_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic                   i_rd_en,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !o_empty;

    // Pointers are exactly log2(DEPTH) bits so they wrap without extra logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule

`default_nettype wire

// File: rtl/harness_resp.sv
// ============================================================================
// Module      : harness_resp
// Description : Harness responder: accepts push/pop requests into a FIFO and
//               answers each one with an ack/nack pulse after ACK_LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module harness_resp
    import harness_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int ACK_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       x,
    output logic                   ready,
    output logic                   ack,
    output logic                   nack,
    output logic [WIDTH-1:0]       y,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_cnt_w = $clog2(c_ack_lat_max + 1);
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'((ACK_LAT > 1) ? (ACK_LAT - 2) : 0);

    resp_state_e        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ok;
    logic [WIDTH-1:0]   r_y;

    req_kind_e          w_kind;
    logic               w_accept;
    logic               w_wr;
    logic               w_rd;
    logic               w_full;
    logic               w_empty;
    logic [WIDTH-1:0]   w_head;

    assign ready    = (r_state == IDLE) && !reset;
    assign w_accept = valid && ready;
    assign w_kind   = classify_req(push, pop);

    // The FIFO commits on the accept edge; only the pulse is delayed.
    assign w_wr = w_accept && (w_kind == PUSH) && !w_full;
    assign w_rd = w_accept && (w_kind == POP)  && !w_empty;

    harness_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_wr_en (w_wr),
        .i_rd_en (w_rd),
        .i_wdata (x),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ok    <= 1'b0;
            r_y     <= '0;
        end else begin
            if (w_rd) begin
                r_y <= w_head;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ok    <= w_wr || w_rd;
                        r_cnt   <= c_wait_load;
                        r_state <= (ACK_LAT > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack  = (r_state == RESP) &&  r_ok;
    assign nack = (r_state == RESP) && !r_ok;
    assign y    = r_y;

endmodule

`default_nettype wire

// File: tb/tb_harness_resp.sv
// ============================================================================
// Module      : tb_harness_resp
// Description : Randomised scoreboard bench for harness_resp at several latencies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_harness_resp;

    typedef struct packed {
        logic ok;
        int   due;
    } exp_t;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int lane, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s lane=%0d t=%0t actual=%0d expected=%0d", nm, lane, $time, act, exp_v);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int LAT   = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        localparam int DEPTH = 8;

        logic       reset = 1'b1;
        logic       valid = 1'b0;
        logic       push  = 1'b0;
        logic       pop   = 1'b0;
        logic [7:0] x     = 8'h00;
        logic       ready;
        logic       ack;
        logic       nack;
        logic [7:0] y;
        logic [3:0] count;

        // Reference model: FIFO contents, last popped word, pending responses.
        logic [7:0] mq[$];
        logic [7:0] my       = 8'h00;
        exp_t       eq[$];
        bit         rst      = 1'b1;
        int         cyc      = 0;
        int         busy_end = 0;
        bit         armed    = 1'b0;
        bit         lane_done = 1'b0;

        harness_resp #(
            .WIDTH   (8),
            .DEPTH   (DEPTH),
            .ACK_LAT (LAT)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .valid (valid),
            .push  (push),
            .pop   (pop),
            .x     (x),
            .ready (ready),
            .ack   (ack),
            .nack  (nack),
            .y     (y),
            .count (count)
        );

        task automatic model_accept(input logic p, input logic q, input logic [7:0] d);
            exp_t e;
            int   t;
            t = cyc + 1;
            e.ok = 1'b0;
            if (p && !q) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(d);
                    e.ok = 1'b1;
                end
            end else if (q && !p) begin
                if (mq.size() > 0) begin
                    my   = mq.pop_front();
                    e.ok = 1'b1;
                end
            end
            e.due    = t + LAT - 1;
            busy_end = t + LAT;
            eq.push_back(e);
        endtask

        // While the responder is busy the bus carries junk, which must be ignored.
        task automatic drive_cycle(input logic want, input logic p, input logic q,
                                   input logic [7:0] d, output bit acc);
            @(negedge clk);
            if (!rst && cyc >= busy_end) begin
                valid = want;
                push  = p;
                pop   = q;
                x     = d;
                if (want) begin
                    model_accept(p, q, d);
                end
                acc = want;
            end else begin
                valid = 1'($urandom);
                push  = 1'($urandom);
                pop   = 1'($urandom);
                x     = 8'($urandom);
                acc   = 1'b0;
            end
        endtask

        task automatic send(input logic p, input logic q, input logic [7:0] d);
            bit acc;
            acc = 1'b0;
            for (int k = 0; k < 40 && !acc; k++) begin
                drive_cycle(1'b1, p, q, d, acc);
            end
        endtask

        task automatic idle(input int n);
            bit acc;
            for (int k = 0; k < n; k++) begin
                drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
            end
        endtask

        task automatic pulse_reset(input int n);
            @(negedge clk);
            reset    = 1'b1;
            rst      = 1'b1;
            valid    = 1'b1;
            mq.delete();
            eq.delete();
            my       = 8'h00;
            busy_end = 0;
            for (int k = 1; k < n; k++) begin
                @(negedge clk);
            end
            @(negedge clk);
            reset = 1'b0;
            rst   = 1'b0;
            valid = 1'b0;
        endtask

        initial begin : monitor
            exp_t e;
            forever begin
                @(posedge clk);
                cyc = cyc + 1;
                #1;
                if (armed) begin
                    check("ready", g, int'(ready), int'(!rst && cyc >= busy_end));
                    check("count", g, int'(count), mq.size());
                    check("y", g, int'(y), int'(my));
                    check("ack_nack_excl", g, int'(ack && nack), 0);
                    if (eq.size() > 0 && eq[0].due <= cyc) begin
                        e = eq.pop_front();
                        check("resp_pulse", g, int'(ack || nack), 1);
                        if (ack || nack) begin
                            check("resp_kind_ack", g, int'(ack), int'(e.ok));
                        end
                    end else if (ack || nack) begin
                        check("resp_unexpected", g, int'({ack, nack}), 0);
                    end
                end
            end
        end

        initial begin : driver
            int r;
            @(negedge clk);
            armed = 1'b1;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            rst   = 1'b0;

            send(1'b1, 1'b0, 8'hA5);
            send(1'b0, 1'b1, 8'h00);

            for (int i = 1; i <= DEPTH + 1; i++) begin
                send(1'b1, 1'b0, 8'(i));
            end
            for (int i = 0; i <= DEPTH; i++) begin
                send(1'b0, 1'b1, 8'h00);
            end

            send(1'b1, 1'b1, 8'h5A);
            send(1'b0, 1'b0, 8'h5A);
            send(1'b1, 1'b0, 8'h77);
            send(1'b1, 1'b1, 8'h11);
            send(1'b0, 1'b0, 8'h22);

            for (int i = 0; i < 200; i++) begin
                r = $urandom_range(0, 19);
                if (r < 3) begin
                    idle(1);
                end else if (r < 11) begin
                    send(1'b1, 1'b0, 8'($urandom));
                end else if (r < 18) begin
                    send(1'b0, 1'b1, 8'($urandom));
                end else begin
                    send(1'(r == 18), 1'(r == 18), 8'($urandom));
                end
            end

            idle(LAT + 2);
            send(1'b1, 1'b0, 8'h3C);
            pulse_reset(1);
            idle(LAT + 6);
            send(1'b1, 1'b0, 8'hC3);
            idle(LAT + 3);
            lane_done = 1'b1;
        end
    end

    initial begin : supervisor
        logic [2:0] done;
        done = 3'b000;
        for (int k = 0; k < 20000 && done != 3'b111; k++) begin
            @(posedge clk);
            done = {g_lane[2].lane_done, g_lane[1].lane_done, g_lane[0].lane_done};
        end
        check("lanes_finished", -1, int'(done), 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
